mipi_csi_frame_controller: RTL and testbench
============================================

# mipi_csi_frame_controller

Sequences the 4-lane MIPI CSI-2 receive path behind `mipi_csi_packet_decoder`. It enables the decoder and tracks frame-start, long-packet and frame-end events. It converts decoded payload into framed pixel-word strobes (frame/line/pixel valid) and counts lines. A watchdog and sticky error flags recover the pipeline from truncated or malformed traffic.

## Interface
- `TIMEOUT_CYCLES`, 1024: max idle cycles inside a long packet before abort (≥2).
- `LINES_PER_FRAME`, 1080: expected long packets between FS and FE (checked only under macro).
- `clk_i`  in  1  receive byte clock, rising edge.
- `reset_n_i`  in  1  reset, asynchronous assert, active-low; all state and outputs clear immediately.
- `enable_i`  in  1  run request; sampled only in IDLE.
- `clear_err_i`  in  1  one-cycle pulse, clears `err_o`.
- `decoder_enable_o`  out  1  drives decoder `data_valid_i`.
- `decoder_valid_i`  in  1  decoder `output_valid_o`.
- `decoder_data_i`  in  32  decoder `data_o` payload word.
- `packet_type_i`  in  3  decoder type: 0 = FS, 1 = FE, 2 = long pixel packet, others ignored.
- `packet_length_i`  in  16  long-packet byte count (low 16 bits of decoder length).
- `frame_valid_o`  out  1  high from FS to FE/abort.
- `line_valid_o`  out  1  high across the payload words of the current long packet.
- `pixel_valid_o`  out  1  one strobe per accepted payload word.
- `pixel_data_o`  out  32  accepted payload word.
- `line_count_o`  out  16  long packets completed in the current frame.
- `frame_done_o`  out  1  one-cycle pulse on FE or abort.
- `err_o`  out  4  sticky flags: [0] timeout, [1] protocol, [2] line count, [3] overrun.

## Operation
- Reset values: all outputs 0, `line_count_o` = 0, state = IDLE.
- Header sampling:
  - `packet_type_i`/`packet_length_i` are sampled only on the first cycle of a `decoder_valid_i` burst (a rising edge of valid).
  - Short packets have valid high for exactly one cycle.
  - For long packets, the first valid cycle already carries payload word 0.
- States:
  - IDLE: `decoder_enable_o` = `enable_i`. An FS sets `frame_valid_o` and clears `line_count_o`, then goes to FRAME. A long packet or FE in IDLE sets err[1] and is ignored.
  - FRAME: a long packet with length > 0 loads `words_left = (len+3)>>2` (15 bits), accepts word 0 and goes to LINE. If `words_left` is 1, it completes immediately and stays in FRAME. A long packet with length 0 sets err[1] and is ignored. FE pulses `frame_done_o`, drops `frame_valid_o`, runs the optional line check and goes to IDLE. FS sets err[1] and restarts the frame (count cleared).
  - LINE: each valid cycle emits `pixel_valid_o` and decrements `words_left`. When `words_left` reaches 0, `line_count_o` increments (saturating at 0xFFFF), `line_valid_o` drops and the block returns to FRAME.
- Stalls: valid may drop mid-packet; the watchdog counts consecutive invalid cycles in LINE.
- Overrun: valid still high after the last word. Excess words are dropped, err[3] is set, and no new header is sampled until valid falls.
- Timeout: watchdog reaches `TIMEOUT_CYCLES` in LINE. err[0] is set, `frame_done_o` pulses, frame/line valid clear, and the block goes to IDLE. `decoder_enable_o` is forced low for one cycle to resync the aligner.
- `enable_i` deasserted mid-frame takes effect only on return to IDLE.
- Error flags: `clear_err_i` zeroes `err_o`. An error raised in the same cycle wins, so that bit reads 1.

## Timing
- Registered outputs. `pixel_valid_o`/`pixel_data_o` lag `decoder_valid_i`/`decoder_data_i` by 1 cycle.
- `frame_valid_o` rises 1 cycle after the FS valid cycle and falls 1 cycle after the FE valid cycle, coincident with `frame_done_o`.
- `line_valid_o` rises with the first `pixel_valid_o` and falls the cycle after the last.
- `line_count_o` updates in the same cycle `line_valid_o` falls.
- `reset_n_i` low mid-packet: outputs clear asynchronously. The first event after release is treated as in IDLE.

## Configuration
- `MIPI_CSI_FRAME_CTRL_LINE_CHECK_EN` defined: at FE, if `line_count_o` ≠ `LINES_PER_FRAME`, err[2] is set in the `frame_done_o` cycle.
- Macro undefined: no comparison logic is built; err[2] is tied to 0.

## Test plan
- Reset, `enable_i`=1, FS, 3 long packets of length 8, FE → 6 `pixel_valid_o` strobes with data matching input, `line_count_o`=3, one `frame_done_o`, `err_o`=0.
- Long packet of length 10 with a 5-cycle valid gap after word 1, `TIMEOUT_CYCLES`=16 → 3 words emitted, no error.
- Long packet of length 0x980 and valid dropped after 100 words, `TIMEOUT_CYCLES`=16 → err[0] set 16 cycles after the drop, `frame_done_o` pulse, IDLE.
- Long packet of length 8 with valid held 4 cycles → 2 words emitted, err[3]=1; `clear_err_i` → `err_o`=0.
- FE in IDLE, then FS twice → err[1]=1, second FS restarts with `line_count_o`=0.
- With macro, `LINES_PER_FRAME`=2, 3 lines then FE → err[2]=1; without macro → err[2]=0.

Source files
------------

// File: rtl/mipi_csi_frame_controller.sv
// mipi_csi_frame_controller
// Frames decoded CSI-2 payload into frame/line/pixel strobes, counts lines
// and recovers from truncated or malformed traffic with a watchdog and
// sticky error flags.
// Optional build macro: MIPI_CSI_FRAME_CTRL_LINE_CHECK_EN enables the
// line-count check at frame end (err[2]); otherwise err[2] is tied to 0.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no frame open; decoder enable follows enable_i
// ST_FRAME | inside FS..FE, waiting for a long packet header or FE
// ST_LINE  | inside a long packet, consuming payload words

module mipi_csi_frame_controller #(
  parameter int unsigned TIMEOUT_CYCLES  = 1024,
  parameter int unsigned LINES_PER_FRAME = 1080
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        enable_i,
  input  logic        clear_err_i,
  output logic        decoder_enable_o,
  input  logic        decoder_valid_i,
  input  logic [31:0] decoder_data_i,
  input  logic [2:0]  packet_type_i,
  input  logic [15:0] packet_length_i,
  output logic        frame_valid_o,
  output logic        line_valid_o,
  output logic        pixel_valid_o,
  output logic [31:0] pixel_data_o,
  output logic [15:0] line_count_o,
  output logic        frame_done_o,
  output logic [3:0]  err_o
);

  localparam int unsigned WDW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] PT_FS   = 3'd0;
  localparam logic [2:0] PT_FE   = 3'd1;
  localparam logic [2:0] PT_LONG = 3'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_FRAME, ST_LINE} state_t;

  state_t          state, state_nxt;
  logic [14:0]     words_left, words_left_nxt;
  logic [WDW-1:0]  wdog, wdog_nxt;
  logic            valid_q;
  logic            armed_q, armed_nxt;
  logic            line_end_q, line_end_nxt;

  logic            dec_en_nxt;
  logic            frame_valid_nxt, line_valid_nxt, pixel_valid_nxt, frame_done_nxt;
  logic [31:0]     pixel_data_nxt;
  logic [15:0]     line_count_nxt;
  logic [3:0]      err_set, err_nxt;
  logic            abort;

  logic            hdr;
  logic [14:0]     len_words;

  // a header is only present on the first cycle of a valid burst
  assign hdr       = decoder_valid_i & ~valid_q;
  assign len_words = 15'(({1'b0, packet_length_i} + 17'd3) >> 2);

`ifndef MIPI_CSI_FRAME_CTRL_LINE_CHECK_EN
  logic [31:0] unused_lines_per_frame;
  assign unused_lines_per_frame = 32'(LINES_PER_FRAME);
`endif

  // state and registered outputs
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state            <= ST_IDLE;
      words_left       <= '0;
      wdog             <= '0;
      valid_q          <= 1'b0;
      armed_q          <= 1'b0;
      line_end_q       <= 1'b0;
      decoder_enable_o <= 1'b0;
      frame_valid_o    <= 1'b0;
      line_valid_o     <= 1'b0;
      pixel_valid_o    <= 1'b0;
      pixel_data_o     <= '0;
      line_count_o     <= '0;
      frame_done_o     <= 1'b0;
      err_o            <= '0;
    end else begin
      state            <= state_nxt;
      words_left       <= words_left_nxt;
      wdog             <= wdog_nxt;
      valid_q          <= decoder_valid_i;
      armed_q          <= armed_nxt;
      line_end_q       <= line_end_nxt;
      decoder_enable_o <= dec_en_nxt;
      frame_valid_o    <= frame_valid_nxt;
      line_valid_o     <= line_valid_nxt;
      pixel_valid_o    <= pixel_valid_nxt;
      pixel_data_o     <= pixel_data_nxt;
      line_count_o     <= line_count_nxt;
      frame_done_o     <= frame_done_nxt;
      err_o            <= err_nxt;
    end
  end

  // next-state and next-output decode
  always_comb begin
    state_nxt       = state;
    words_left_nxt  = words_left;
    wdog_nxt        = '0;
    armed_nxt       = armed_q & decoder_valid_i;
    line_end_nxt    = 1'b0;
    frame_valid_nxt = frame_valid_o;
    line_valid_nxt  = line_valid_o;
    pixel_valid_nxt = 1'b0;
    pixel_data_nxt  = pixel_data_o;
    line_count_nxt  = line_count_o;
    frame_done_nxt  = 1'b0;
    err_set         = '0;
    abort           = 1'b0;

    // the cycle after the last word closes the line
    if (line_end_q) begin
      line_valid_nxt = 1'b0;
      if (line_count_o != 16'hFFFF) line_count_nxt = line_count_o + 16'd1;
    end

    case (state)
      ST_IDLE: begin
        if (hdr) begin
          if (packet_type_i == PT_FS) begin
            frame_valid_nxt = 1'b1;
            line_count_nxt  = '0;
            state_nxt       = ST_FRAME;
          end else if (packet_type_i == PT_FE || packet_type_i == PT_LONG) begin
            err_set[1] = 1'b1;
          end
        end
      end

      ST_FRAME: begin
        if (hdr) begin
          if (packet_type_i == PT_FS) begin
            err_set[1]     = 1'b1;
            line_count_nxt = '0;
          end else if (packet_type_i == PT_FE) begin
            frame_done_nxt  = 1'b1;
            frame_valid_nxt = 1'b0;
            state_nxt       = ST_IDLE;
`ifdef MIPI_CSI_FRAME_CTRL_LINE_CHECK_EN
            if (line_count_o != 16'(LINES_PER_FRAME)) err_set[2] = 1'b1;
`endif
          end else if (packet_type_i == PT_LONG) begin
            if (packet_length_i == 16'd0) begin
              err_set[1] = 1'b1;
            end else begin
              pixel_valid_nxt = 1'b1;
              pixel_data_nxt  = decoder_data_i;
              line_valid_nxt  = 1'b1;
              words_left_nxt  = len_words - 15'd1;
              if (len_words == 15'd1) begin
                line_end_nxt = 1'b1;
                armed_nxt    = 1'b1;
              end else begin
                state_nxt = ST_LINE;
              end
            end
          end
        end else if (decoder_valid_i && armed_q) begin
          // words beyond the advertised length are dropped
          err_set[3] = 1'b1;
        end
      end

      ST_LINE: begin
        if (decoder_valid_i) begin
          pixel_valid_nxt = 1'b1;
          pixel_data_nxt  = decoder_data_i;
          words_left_nxt  = words_left - 15'd1;
          if (words_left == 15'd1) begin
            line_end_nxt = 1'b1;
            armed_nxt    = 1'b1;
            state_nxt    = ST_FRAME;
          end
        end else if (wdog == WDOG_LAST) begin
          abort           = 1'b1;
          err_set[0]      = 1'b1;
          frame_done_nxt  = 1'b1;
          frame_valid_nxt = 1'b0;
          line_valid_nxt  = 1'b0;
          state_nxt       = ST_IDLE;
        end else begin
          wdog_nxt = wdog + 1'b1;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    // abort drops the decoder enable for one cycle so the aligner resyncs
    if (abort)                 dec_en_nxt = 1'b0;
    else if (state == ST_IDLE) dec_en_nxt = enable_i;
    else                       dec_en_nxt = decoder_enable_o;

    // a flag raised in the clearing cycle survives the clear
    err_nxt = (clear_err_i ? 4'b0000 : err_o) | err_set;
  end

endmodule

// File: tb/tb_mipi_csi_frame_controller.sv
// Scoreboard bench for mipi_csi_frame_controller: stimulus pushes expected
// pixel words and frame-done records; monitors pop and compare.
module tb_mipi_csi_frame_controller;

  localparam int TO  = 16;
  localparam int LPF = 2;
`ifdef MIPI_CSI_FRAME_CTRL_LINE_CHECK_EN
  localparam bit LC = 1'b1;
`else
  localparam bit LC = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        enable_i = 1'b0;
  logic        clear_err_i = 1'b0;
  logic        decoder_enable_o;
  logic        decoder_valid_i = 1'b0;
  logic [31:0] decoder_data_i = '0;
  logic [2:0]  packet_type_i = '0;
  logic [15:0] packet_length_i = '0;
  logic        frame_valid_o, line_valid_o, pixel_valid_o, frame_done_o;
  logic [31:0] pixel_data_o;
  logic [15:0] line_count_o;
  logic [3:0]  err_o;

  mipi_csi_frame_controller #(.TIMEOUT_CYCLES(TO), .LINES_PER_FRAME(LPF)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .enable_i(enable_i),
    .clear_err_i(clear_err_i), .decoder_enable_o(decoder_enable_o),
    .decoder_valid_i(decoder_valid_i), .decoder_data_i(decoder_data_i),
    .packet_type_i(packet_type_i), .packet_length_i(packet_length_i),
    .frame_valid_o(frame_valid_o), .line_valid_o(line_valid_o),
    .pixel_valid_o(pixel_valid_o), .pixel_data_o(pixel_data_o),
    .line_count_o(line_count_o), .frame_done_o(frame_done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [15:0] cnt;
    logic [3:0]  err;
  } done_t;

  logic [31:0] pix_q[$];
  done_t       done_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] seq = 16'h0;
  logic [31:0] pe;
  done_t       de;

  function automatic logic [3:0] lc_err(input int cnt);
    return (LC && cnt != LPF) ? 4'b0100 : 4'b0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // pixel and frame-done monitor
  always @(negedge clk_i) begin
    if (reset_n_i) begin
      if (pixel_valid_o) begin
        if (pix_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pixel: got %0h expected none", pixel_data_o);
        end else begin
          pe = pix_q.pop_front();
          check("pixel_data", pixel_data_o, pe);
          check("line_valid_with_pixel", 32'(line_valid_o), 32'd1);
        end
      end
      if (frame_done_o) begin
        if (done_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_frame_done: got pulse expected none");
        end else begin
          de = done_q.pop_front();
          check("done_line_count", 32'(line_count_o), 32'(de.cnt));
          check("done_err", 32'(err_o), 32'(de.err));
          check("done_frame_valid", 32'(frame_valid_o), 32'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    decoder_valid_i = 1'b0;
    repeat (n) tick();
  endtask

  task automatic short_pkt(input logic [2:0] t);
    packet_type_i   = t;
    packet_length_i = 16'd0;
    decoder_valid_i = 1'b1;
    tick();
    decoder_valid_i = 1'b0;
    tick();
  endtask

  task automatic long_pkt(input logic [15:0] len, input int n, input int push_n,
                          input int gap_at, input int gap_len);
    packet_type_i   = 3'd2;
    packet_length_i = len;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at && gap_len > 0) begin
        decoder_valid_i = 1'b0;
        repeat (gap_len) tick();
      end
      decoder_data_i  = {8'hC3, 8'(i), seq};
      seq             = seq + 16'd1;
      decoder_valid_i = 1'b1;
      if (i < push_n) pix_q.push_back(decoder_data_i);
      tick();
    end
    decoder_valid_i = 1'b0;
    tick();
  endtask

  task automatic clear_err();
    clear_err_i = 1'b1;
    tick();
    clear_err_i = 1'b0;
    tick();
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
  endtask

  initial begin
    #200000;
    miscompares++;
    $display("FAIL global_timeout: got no finish expected finish");
    summary();
    $finish;
  end

  initial begin
    repeat (3) tick();
    check("rst_frame_valid", 32'(frame_valid_o), 32'd0);
    check("rst_line_valid", 32'(line_valid_o), 32'd0);
    check("rst_pixel_valid", 32'(pixel_valid_o), 32'd0);
    check("rst_pixel_data", pixel_data_o, 32'd0);
    check("rst_line_count", 32'(line_count_o), 32'd0);
    check("rst_frame_done", 32'(frame_done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_dec_en", 32'(decoder_enable_o), 32'd0);
    reset_n_i = 1'b1;
    enable_i  = 1'b1;
    idle(2);
    check("dec_en_idle", 32'(decoder_enable_o), 32'd1);

    // three 8-byte lines in one frame
    short_pkt(3'd0);
    check("fs_frame_valid", 32'(frame_valid_o), 32'd1);
    for (int l = 0; l < 3; l++) begin
      long_pkt(16'd8, 2, 2, -1, 0);
      idle(1);
    end
    check("t1_line_count", 32'(line_count_o), 32'd3);
    done_q.push_back('{cnt: 16'd3, err: lc_err(3)});
    short_pkt(3'd1);
    idle(2);
    clear_err();

    // stall inside a packet shorter than the watchdog
    short_pkt(3'd0);
    long_pkt(16'd10, 3, 3, 2, 5);
    idle(2);
    check("t2_line_count", 32'(line_count_o), 32'd1);
    check("t2_err", 32'(err_o), 32'd0);
    done_q.push_back('{cnt: 16'd1, err: lc_err(1)});
    short_pkt(3'd1);
    idle(2);
    clear_err();

    // truncated packet: watchdog abort
    short_pkt(3'd0);
    long_pkt(16'h0980, 100, 100, -1, 0);
    repeat (TO - 2) tick();
    check("t3_err_before_timeout", 32'(err_o), 32'd0);
    done_q.push_back('{cnt: 16'd0, err: 4'b0001});
    tick();
    check("t3_err_timeout", 32'(err_o), 32'd1);
    check("t3_dec_en_low", 32'(decoder_enable_o), 32'd0);
    check("t3_frame_valid", 32'(frame_valid_o), 32'd0);
    check("t3_line_valid", 32'(line_valid_o), 32'd0);
    tick();
    check("t3_dec_en_back", 32'(decoder_enable_o), 32'd1);
    idle(2);
    clear_err();
    check("t3_err_cleared", 32'(err_o), 32'd0);

    // overrun: valid held past the last word
    short_pkt(3'd0);
    long_pkt(16'd8, 4, 2, -1, 0);
    idle(2);
    check("t4_err_overrun", 32'(err_o), 32'd8);
    check("t4_line_count", 32'(line_count_o), 32'd1);
    clear_err();
    check("t4_err_cleared", 32'(err_o), 32'd0);
    done_q.push_back('{cnt: 16'd1, err: lc_err(1)});
    short_pkt(3'd1);
    idle(2);
    clear_err();

    // error raised in the clearing cycle survives
    packet_type_i   = 3'd1;
    decoder_valid_i = 1'b1;
    clear_err_i     = 1'b1;
    tick();
    decoder_valid_i = 1'b0;
    clear_err_i     = 1'b0;
    tick();
    check("clear_vs_set", 32'(err_o), 32'd2);
    clear_err();

    // protocol errors: FE in IDLE, then FS twice
    short_pkt(3'd1);
    idle(1);
    check("t5_fe_idle_err", 32'(err_o), 32'd2);
    check("t5_fe_idle_frame", 32'(frame_valid_o), 32'd0);
    clear_err();
    short_pkt(3'd0);
    long_pkt(16'd8, 2, 2, -1, 0);
    idle(2);
    check("t5_count_before", 32'(line_count_o), 32'd1);
    short_pkt(3'd0);
    idle(1);
    check("t5_double_fs_err", 32'(err_o), 32'd2);
    check("t5_restart_count", 32'(line_count_o), 32'd0);
    check("t5_frame_valid", 32'(frame_valid_o), 32'd1);
    done_q.push_back('{cnt: 16'd0, err: 4'b0010 | lc_err(0)});
    short_pkt(3'd1);
    idle(2);
    clear_err();

    // single-word lines and the line-count check
    short_pkt(3'd0);
    for (int l = 0; l < 3; l++) begin
      long_pkt(16'd4, 1, 1, -1, 0);
      idle(1);
    end
    done_q.push_back('{cnt: 16'd3, err: lc_err(3)});
    short_pkt(3'd1);
    idle(2);
    check("t6_err2", 32'(err_o[2]), 32'(LC));

    idle(5);
    check("pix_q_drained", 32'(pix_q.size()), 32'd0);
    check("done_q_drained", 32'(done_q.size()), 32'd0);
    summary();
    $finish;
  end

endmodule
